// File: rtl/fxyz_sweep_checker.sv
// fxyz_sweep_checker
//
// Purpose
//   Drives the eight input vectors {x,y,z} = 000..111 into a combinational
//   fxyz stage. On each of the eight RUN cycles it compares the stage's
//   unsimplified result (s1) with its simplified result (s2). It counts
//   mismatches (saturating) and records the first failing vector. When the
//   sweep ends, the results stay valid in DONE until the next start.
//
// Configuration
//   FXYZ_SWEEP_STOP_ON_FAIL_EN : when defined, the first mismatch ends the
//                                sweep on the same edge. The vector is held
//                                at the failing value and err_cnt is 1.
//                                When undefined, every sweep covers all
//                                eight vectors.
//
// Parameters
//   ERR_W      : width of the mismatch counter (1..8)
//
// Ports
//   clk        : clock, rising edge active
//   rst_n      : asynchronous active-low reset
//   start      : request a sweep (used in IDLE and DONE, ignored in RUN)
//   s1, s2     : unsimplified / simplified results from the stage under test
//   x, y, z    : registered stimulus vector, x is the MSB
//   busy       : sweep in progress
//   done       : sweep complete, results valid
//   pass       : done and no mismatch counted
//   err_cnt    : saturating mismatch count
//   first_fail : vector of the first mismatch, 000 if none
module fxyz_sweep_checker #(
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s1,
  input  logic             s2,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       first_fail
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [2:0]       VEC_LAST = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [2:0]       vec_q,   vec_d;
  logic [ERR_W-1:0] err_q,   err_d;
  logic [2:0]       ff_q,    ff_d;

  logic in_run;
  logic mismatch;

  assign in_run = (state_q == ST_RUN);

  // s1/s2 are qualified by RUN, so unknown or toggling values outside a
  // sweep cannot reach any state.
  assign mismatch = in_run && (s1 != s2);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ff_d    = ff_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A restart from DONE behaves the same as a start from IDLE.
        if (start) begin
          state_d = ST_RUN;
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
        end
      end

      ST_RUN: begin
        if (mismatch) begin
          // err_q is cleared at sweep start and only grows during a sweep.
          // Zero therefore means "no mismatch seen yet".
          if (err_q == '0) begin
            ff_d = vec_q;
          end
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
        end

`ifdef FXYZ_SWEEP_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_d = ST_DONE;
        end else if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d = vec_q + 3'd1;
        end
`else
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d = vec_q + 3'd1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        vec_d   = '0;
        err_d   = '0;
        ff_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign x          = vec_q[2];
  assign y          = vec_q[1];
  assign z          = vec_q[0];
  assign busy       = in_run;
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_q == '0);
  assign err_cnt    = err_q;
  assign first_fail = ff_q;

endmodule
